// File: rtl/inst_rom_arbiter.sv
// Two-requester arbiter in front of a single combinational instruction ROM.
// Fetch (if_*) and data/debug (dm_*) sides share the ROM through a round-robin
// grant; each granted access completes in WAIT_CYCLES+2 cycles, and an illegal
// address is answered with an error response without touching the ROM.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LOG2    = 17,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  // data/debug side
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic              dm_err,
  output logic [DATA_W-1:0] dm_rdata,
  // ROM
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  // Bits at or above MEM_LOG2+2 must be zero; all-zero mask when the ROM
  // spans the full address space.
  localparam logic [ADDR_W-1:0] InRangeMask =
    (ADDR_W'(1) << (MEM_LOG2 + 2)) - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] HighMask = ~InRangeMask;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              last_dm_q;  // 1: dm was granted most recently
  logic              win_dm_q;   // owner of the current transaction
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_err_q, dm_err_q;

  logic              grant_if, grant_dm;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_illegal;

  // Round-robin arbitration, open only outside ACCESS and out of reset.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (rst && (state_q != StAccess)) begin
      if (if_req && dm_req) begin
        grant_if = last_dm_q;
        grant_dm = !last_dm_q;
      end else begin
        grant_if = if_req;
        grant_dm = dm_req;
      end
    end
    sel_addr    = grant_dm ? dm_addr : if_addr;
    sel_illegal = (sel_addr[1:0] != 2'b00) || ((sel_addr & HighMask) != '0);
  end

  // Transaction FSM: grant, ROM access with wait countdown, response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      last_dm_q  <= 1'b1;
      win_dm_q   <= 1'b0;
      addr_q     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_err_q   <= 1'b0;
      dm_err_q   <= 1'b0;
    end else if (grant_if || grant_dm) begin
      last_dm_q <= grant_dm;
      win_dm_q  <= grant_dm;
      addr_q    <= sel_addr;
      if (sel_illegal) begin
        state_q <= StDone;
        if (grant_dm) begin
          dm_rdata_q <= '0;
          dm_err_q   <= 1'b1;
        end else begin
          if_rdata_q <= '0;
          if_err_q   <= 1'b1;
        end
      end else begin
        state_q <= StAccess;
        cnt_q   <= 3'(WAIT_CYCLES);
      end
    end else begin
      case (state_q)
        StAccess: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q <= StDone;
            if (win_dm_q) begin
              dm_rdata_q <= rom_inst;
              dm_err_q   <= 1'b0;
            end else begin
              if_rdata_q <= rom_inst;
              if_err_q   <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode from registered state; gated so nothing leaks during reset.
  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    if_rvalid = rst && (state_q == StDone) && !win_dm_q;
    dm_rvalid = rst && (state_q == StDone) && win_dm_q;
    rom_ce    = rst && (state_q == StAccess);
    rom_addr  = rom_ce ? addr_q : '0;
    // A request being granted this cycle still counts as stalled.
    if_stall  = rst && (if_req || ((state_q == StAccess) && !win_dm_q));
    if_rdata  = if_rdata_q;
    if_err    = if_err_q;
    dm_rdata  = dm_rdata_q;
    dm_err    = dm_err_q;
  end

endmodule

// File: doc/inst_rom_arbiter.md
INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, requester/ROM address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter MEM_LOG2, default 17, log2 of ROM depth in words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, extra ROM access cycles; legal range 0..7.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports if_req in 1, if_addr in ADDR_W: fetch-side request and byte address.
REQ-008 SHALL have ports if_gnt out 1, if_rvalid out 1, if_err out 1, if_rdata out DATA_W: fetch-side grant, response pulse, error flag, read data.
REQ-009 SHALL have ports dm_req in 1, dm_addr in ADDR_W: data/debug-side request and byte address.
REQ-010 SHALL have ports dm_gnt out 1, dm_rvalid out 1, dm_err out 1, dm_rdata out DATA_W: data-side equivalents.
REQ-011 SHALL have ports rom_ce out 1, rom_addr out ADDR_W, rom_inst in DATA_W: ROM chip enable, byte address, combinational ROM read data.
REQ-012 SHALL have port if_stall out 1: fetch request pending or outstanding.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-014 In IDLE or DONE, any asserted req SHALL be arbitrated and the winner's gnt asserted combinationally for exactly that cycle; addr and winner id SHALL be latched.
REQ-015 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; a single requester always wins.
REQ-016 Requester SHALL hold req and addr stable until gnt; a cycle with req=1 and gnt=1 consumes the request.
REQ-017 Latched addr is illegal if addr[1:0]!=0 or any bit addr[ADDR_W-1:MEM_LOG2+2]!=0.
REQ-018 Legal grant SHALL move to ACCESS with wait counter loaded with WAIT_CYCLES; illegal grant SHALL move directly to DONE with err=1, rdata=0, no rom_ce.
REQ-019 In ACCESS, rom_ce=1 and rom_addr=latched addr; counter nonzero: decrement, stay; counter zero: capture rom_inst into rdata register, go DONE.
REQ-020 rom_ce SHALL be 0 and rom_addr 0 outside ACCESS.
REQ-021 In DONE, the winner's rvalid SHALL pulse for one cycle with rdata/err valid; the other requester's rvalid SHALL stay 0.
REQ-022 rdata and err SHALL hold their value until the next DONE; meaningful only when rvalid=1.
REQ-023 From DONE: new grant -> ACCESS (legal) or DONE (illegal); no request -> IDLE.
REQ-024 Legal-access latency: gnt in cycle N, rvalid in cycle N+WAIT_CYCLES+2; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
REQ-025 Round-robin pointer SHALL update on each grant.
REQ-026 if_stall = (if_req and not if_gnt) or (fetch transaction granted and its rvalid not yet asserted).
REQ-027 Requests arriving during ACCESS SHALL wait; no gnt is issued in ACCESS.

Reset
REQ-028 With rst=0 at a clock edge: state IDLE, counter 0, pointer = dm (fetch wins first tie), rdata registers 0, err 0.
REQ-029 During reset all gnt, rvalid, rom_ce, if_stall outputs SHALL be 0.
REQ-030 Reset during ACCESS or DONE SHALL abort the transaction; no rvalid SHALL follow.

Verification
REQ-031 WAIT_CYCLES=0, if_req addr 0x00000010, ROM word 4 = 0x34010001 -> if_gnt cycle N, rom_ce=1 with rom_addr 0x10 at N+1, if_rvalid with if_rdata 0x34010001 at N+2.
REQ-032 Both req asserted continuously from reset release -> grants alternate if, dm, if, dm; every rvalid goes to the matching requester.
REQ-033 dm_req addr 0x00000006 (misaligned), then 0x00080000 (MEM_LOG2=17, out of range) -> dm_rvalid, dm_err=1, dm_rdata=0 one cycle after each gnt; rom_ce never 1.
REQ-034 WAIT_CYCLES=3, if_req addr 0x4 -> rom_ce high 4 cycles, if_rvalid at N+5, if_stall high from request through N+4, low at N+5.
REQ-035 rst=0 asserted during ACCESS -> next cycle IDLE, rom_ce=0, no rvalid; fetch wins first grant after release.
REQ-036 dm granted, if_req raised during ACCESS -> no if_gnt until DONE; if_gnt coincides with dm_rvalid.
